fsm1_pulse_sequencer: RTL and testbench

FSM1_PULSE_SEQUENCER -- requirements
Module: fsm1_pulse_sequencer

---
 rtl/fsm1_seq_pkg.sv | 37 +++
 rtl/fsm1_seq_vecmem.sv | 30 +++
 rtl/fsm1_pulse_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_fsm1_pulse_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm1_seq_pkg.sv
// Shared types and constants for the fsm1_route pulse sequencer: controller
// states, the layout of one 6-bit test vector, and the default memory depth.
package fsm1_seq_pkg;

   localparam int DEPTH_DEFAULT = 16;

   // One vector: [2:0] stimulus {reset, input2, input1}, [5:3] expected
   // observation {output1, state_obs1, state_obs0}.
   localparam int VEC_W    = 6;
   localparam int STIM_LSB = 0;
   localparam int STIM_W   = 3;
   localparam int EXP_LSB  = 3;
   localparam int EXP_W    = 3;

   // Bit positions inside the stimulus field.
   localparam int BIT_INPUT1    = 0;
   localparam int BIT_INPUT2    = 1;
   localparam int BIT_FSM_RESET = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_APPLY,
      ST_DRAIN,
      ST_FLUSH,
      ST_DONE
   } state_e;

   function automatic logic [STIM_W-1:0] vec_stim(input logic [VEC_W-1:0] v);
      return v[STIM_LSB +: STIM_W];
   endfunction

   function automatic logic [EXP_W-1:0] vec_exp(input logic [VEC_W-1:0] v);
      return v[EXP_LSB +: EXP_W];
   endfunction

endpackage

// File: rtl/fsm1_seq_vecmem.sv
// Test-vector register file: DEPTH entries of one packed vector each, one
// synchronous write port and one combinational read port.
module fsm1_seq_vecmem
   import fsm1_seq_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEFAULT,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [VEC_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [VEC_W-1:0] rdata
);

   // NOTE: the storage array has no reset; vectors must survive a controller
   // reset, and leaving it unreset keeps it mappable onto plain RAM cells.
   logic [VEC_W-1:0] mem_q [DEPTH];

   // Write port: one entry per enabled rising edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fsm1_pulse_sequencer.sv
// Drives stored stimulus vectors into the fsm1_route core one per cycle,
// compares the core's observation lines one cycle later against the stored
// expectation, and reports mismatch count and first failing index.
module fsm1_pulse_sequencer
   import fsm1_seq_pkg::*;
#(
   parameter  int DEPTH  = DEPTH_DEFAULT,
   parameter  int WARMUP = 20,
   parameter  int FLUSH  = 20,
   localparam int AW     = $clog2(DEPTH),
   localparam int NW     = $clog2(DEPTH + 1)
) (
   input  logic             GCLK_Pad,
   input  logic             reset_Pad,
   input  logic             start_Pad,
   input  logic [NW-1:0]    num_vec_Pad,
   input  logic             cfg_we_Pad,
   input  logic [AW-1:0]    cfg_addr_Pad,
   input  logic [VEC_W-1:0] cfg_data_Pad,
   output logic             input1_Pad,
   output logic             input2_Pad,
   output logic             fsm_reset_Pad,
   input  logic             state_obs0_Pad,
   input  logic             state_obs1_Pad,
   input  logic             output1_Pad,
   output logic             busy_Pad,
   output logic             done_Pad,
   output logic [NW-1:0]    mismatch_cnt_Pad,
   output logic [AW-1:0]    first_fail_Pad,
   output logic             fail_valid_Pad
);

   // Shared down-counter for the WARMUP and FLUSH idle phases.
   localparam int CNT_MAX = (WARMUP > FLUSH) ? WARMUP : FLUSH;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] WARMUP_LOAD = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam logic [CW-1:0] FLUSH_LOAD  = CW'((FLUSH > 0) ? FLUSH - 1 : 0);

   state_e             state_q,      state_d;
   logic [CW-1:0]      cnt_q,        cnt_d;
   logic [NW-1:0]      vec_idx_q,    vec_idx_d;    // next vector to apply
   logic [NW-1:0]      num_vec_q,    num_vec_d;
   logic [STIM_W-1:0]  stim_q,       stim_d;
   // Stage 1: vector currently on the stimulus pins.
   logic               cur_valid_q,  cur_valid_d;
   logic [EXP_W-1:0]   cur_exp_q,    cur_exp_d;
   logic [AW-1:0]      cur_idx_q,    cur_idx_d;
   // Stage 2: vector whose response is on the observation lines now.
   logic               chk_valid_q,  chk_valid_d;
   logic [EXP_W-1:0]   chk_exp_q,    chk_exp_d;
   logic [AW-1:0]      chk_idx_q,    chk_idx_d;
   logic [NW-1:0]      mismatch_q,   mismatch_d;
   logic [AW-1:0]      first_fail_q, first_fail_d;
   logic               fail_valid_q, fail_valid_d;
   logic               busy_q,       busy_d;
   logic               done_q,       done_d;

   logic [AW-1:0]      rd_addr;
   logic [VEC_W-1:0]   rd_data;
   logic               mem_we;
   logic [EXP_W-1:0]   obs;
   logic [NW-1:0]      start_nv;
   logic [NW-1:0]      run_nv;
   logic               go_run;
   logic               go_flush;
   logic               load_vec;

   // Configuration writes are only honoured while idle and not in reset.
   assign mem_we  = cfg_we_Pad && (state_q == ST_IDLE) && !reset_Pad;
   assign rd_addr = (state_q == ST_APPLY) ? vec_idx_q[AW-1:0] : '0;
   assign obs     = {output1_Pad, state_obs1_Pad, state_obs0_Pad};

   // Requested vector count, clamped to the memory depth.
   assign start_nv = (num_vec_Pad > NW'(DEPTH)) ? NW'(DEPTH) : num_vec_Pad;
   // Count in force for the run: the latched one, or the one being latched.
   assign run_nv   = (state_q == ST_IDLE) ? start_nv : num_vec_q;

   fsm1_seq_vecmem #(.DEPTH(DEPTH)) u_vecmem (
      .clk   (GCLK_Pad),
      .we    (mem_we),
      .waddr (cfg_addr_Pad),
      .wdata (cfg_data_Pad),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Next-state, stimulus pipeline and scoring logic.
   always_comb begin
      // NOTE: every variable gets a default before any branch so that no
      // path leaves it unassigned, which would infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      vec_idx_d    = vec_idx_q;
      num_vec_d    = num_vec_q;
      stim_d       = '0;
      cur_valid_d  = 1'b0;
      cur_exp_d    = cur_exp_q;
      cur_idx_d    = cur_idx_q;
      chk_valid_d  = cur_valid_q;
      chk_exp_d    = cur_exp_q;
      chk_idx_d    = cur_idx_q;
      mismatch_d   = mismatch_q;
      first_fail_d = first_fail_q;
      fail_valid_d = fail_valid_q;
      go_run       = 1'b0;
      go_flush     = 1'b0;
      load_vec     = 1'b0;

      // The response to the vector driven last cycle is on the pins now.
      if (chk_valid_q && (obs != chk_exp_q)) begin
         mismatch_d = mismatch_q + NW'(1);
         if (!fail_valid_q) begin
            first_fail_d = chk_idx_q;
            fail_valid_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start_Pad) begin
               num_vec_d    = start_nv;
               vec_idx_d    = '0;
               mismatch_d   = '0;
               first_fail_d = '0;
               fail_valid_d = 1'b0;
               if (WARMUP > 0) begin
                  state_d = ST_WARMUP;
                  cnt_d   = WARMUP_LOAD;
               end else begin
                  go_run = 1'b1;
               end
            end
         end
         ST_WARMUP: begin
            if (cnt_q == '0) go_run = 1'b1;
            else             cnt_d  = cnt_q - CW'(1);
         end
         ST_APPLY: begin
            if (vec_idx_q < num_vec_q) load_vec = 1'b1;
            else                       state_d  = ST_DRAIN;
         end
         ST_DRAIN: go_flush = 1'b1;
         ST_FLUSH: begin
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Leaving the warm-up: apply vectors, or skip straight to the flush.
      if (go_run) begin
         if (run_nv == '0) begin
            go_flush = 1'b1;
         end else begin
            state_d  = ST_APPLY;
            load_vec = 1'b1;
         end
      end

      if (go_flush) begin
         if (FLUSH > 0) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
         end else begin
            state_d = ST_DONE;
         end
      end

      if (load_vec) begin
         stim_d      = vec_stim(rd_data);
         cur_valid_d = 1'b1;
         cur_exp_d   = vec_exp(rd_data);
         cur_idx_d   = rd_addr;
         vec_idx_d   = {1'b0, rd_addr} + NW'(1);
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State register with synchronous reset; vector memory is left untouched.
   always_ff @(posedge GCLK_Pad) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset_Pad) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         vec_idx_q    <= '0;
         num_vec_q    <= '0;
         stim_q       <= '0;
         cur_valid_q  <= 1'b0;
         cur_exp_q    <= '0;
         cur_idx_q    <= '0;
         chk_valid_q  <= 1'b0;
         chk_exp_q    <= '0;
         chk_idx_q    <= '0;
         mismatch_q   <= '0;
         first_fail_q <= '0;
         fail_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vec_idx_q    <= vec_idx_d;
         num_vec_q    <= num_vec_d;
         stim_q       <= stim_d;
         cur_valid_q  <= cur_valid_d;
         cur_exp_q    <= cur_exp_d;
         cur_idx_q    <= cur_idx_d;
         chk_valid_q  <= chk_valid_d;
         chk_exp_q    <= chk_exp_d;
         chk_idx_q    <= chk_idx_d;
         mismatch_q   <= mismatch_d;
         first_fail_q <= first_fail_d;
         fail_valid_q <= fail_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign input1_Pad       = stim_q[BIT_INPUT1];
   assign input2_Pad       = stim_q[BIT_INPUT2];
   assign fsm_reset_Pad    = stim_q[BIT_FSM_RESET];
   assign busy_Pad         = busy_q;
   assign done_Pad         = done_q;
   assign mismatch_cnt_Pad = mismatch_q;
   assign first_fail_Pad   = first_fail_q;
   assign fail_valid_Pad   = fail_valid_q;

endmodule

// File: tb/tb_fsm1_pulse_sequencer.sv
// Bench for fsm1_pulse_sequencer: a small behavioural fsm1_route core answers
// the stimulus pulses, and a table of runs plus a few hand sequences check
// timing, scoring, clamping, busy-time isolation and reset behaviour.
module tb_fsm1_pulse_sequencer;

   logic       clk = 1'b0;
   logic       reset_pad = 1'b0;
   logic       start_pad = 1'b0;
   logic [4:0] num_vec_pad = '0;
   logic       cfg_we_pad = 1'b0;
   logic [3:0] cfg_addr_pad = '0;
   logic [5:0] cfg_data_pad = '0;
   logic       input1, input2, fsm_reset;
   logic       obs0, obs1, out1;
   logic       busy, done;
   logic [4:0] mismatch_cnt;
   logic [3:0] first_fail;
   logic       fail_valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fsm1_pulse_sequencer dut (
      .GCLK_Pad         (clk),
      .reset_Pad        (reset_pad),
      .start_Pad        (start_pad),
      .num_vec_Pad      (num_vec_pad),
      .cfg_we_Pad       (cfg_we_pad),
      .cfg_addr_Pad     (cfg_addr_pad),
      .cfg_data_Pad     (cfg_data_pad),
      .input1_Pad       (input1),
      .input2_Pad       (input2),
      .fsm_reset_Pad    (fsm_reset),
      .state_obs0_Pad   (obs0),
      .state_obs1_Pad   (obs1),
      .output1_Pad      (out1),
      .busy_Pad         (busy),
      .done_Pad         (done),
      .mismatch_cnt_Pad (mismatch_cnt),
      .first_fail_Pad   (first_fail),
      .fail_valid_Pad   (fail_valid)
   );

   // Core model: 2-bit counter, input1 counts up, input2 counts down, both or
   // neither hold; output1 is high while the counter sits at 3. One-cycle
   // registered response.
   logic [1:0] core_st  = 2'd0;
   logic       core_out = 1'b0;

   function automatic logic [1:0] core_next(input logic [1:0] st, input logic i1, input logic i2);
      if (i1 && !i2) return st + 2'd1;
      if (i2 && !i1) return st - 2'd1;
      return st;
   endfunction

   always @(posedge clk) begin
      if (fsm_reset) begin
         core_st  <= 2'd0;
         core_out <= 1'b0;
      end else begin
         core_st  <= core_next(core_st, input1, input2);
         core_out <= (core_next(core_st, input1, input2) == 2'd3);
      end
   end

   assign obs0 = core_st[0];
   assign obs1 = core_st[1];
   assign out1 = core_out;

   // Hand-computed golden vectors: stimulus {rst,i2,i1}, expected {out,st1,st0}.
   logic [2:0] gs [16];
   logic [2:0] ge [16];

   typedef struct {
      int          nv;
      logic        reload;
      logic [15:0] corrupt;
      int          disturb;   // cycle after start at which start/cfg_we pulse, 0 = none
      int          exp_done;
      int          exp_mm;
      int          exp_ff;
      logic        exp_fv;
      int          applied;
   } run_t;

   run_t rows [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic load_mem(input logic [15:0] corrupt);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         cfg_we_pad   = 1'b1;
         cfg_addr_pad = 4'(i);
         cfg_data_pad = {ge[i] ^ (corrupt[i] ? 3'b111 : 3'b000), gs[i]};
      end
      @(negedge clk);
      cfg_we_pad = 1'b0;
   endtask

   // Start a run at a falling edge, trace it cycle by cycle, then check results.
   task automatic do_run(input string tag, input run_t r);
      int         done_cyc = 0;
      int         stim_bad = 0;
      int         first_bad = 0;
      int         busy_bad = 0;
      logic [2:0] s, es;
      if (r.reload) load_mem(r.corrupt);
      @(negedge clk);
      start_pad   = 1'b1;
      num_vec_pad = 5'(r.nv);
      @(negedge clk);
      start_pad   = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         start_pad    = (cyc == r.disturb);
         cfg_we_pad   = (cyc == r.disturb);
         cfg_addr_pad = 4'd1;
         cfg_data_pad = 6'h3f;
         s  = {fsm_reset, input2, input1};
         es = (cyc >= 21 && cyc < 21 + r.applied) ? gs[cyc - 21] : 3'b000;
         if (s !== es) begin
            if (stim_bad == 0) first_bad = cyc;
            stim_bad++;
         end
         if (busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      start_pad  = 1'b0;
      cfg_we_pad = 1'b0;
      check({tag, "_done_cycle"}, done_cyc, r.exp_done);
      check({tag, "_stim_trace_bad_cycles"}, stim_bad, 0);
      if (stim_bad != 0) $display("  %s first stimulus deviation at cycle %0d", tag, first_bad);
      check({tag, "_busy_low_cycles"}, busy_bad, 0);
      check({tag, "_mismatch_cnt"}, mismatch_cnt, r.exp_mm);
      check({tag, "_first_fail"}, first_fail, r.exp_ff);
      check({tag, "_fail_valid"}, fail_valid, r.exp_fv);
      @(negedge clk);
      check({tag, "_after_done_busy_done"}, {busy, done}, 2'b00);
   endtask

   initial begin
      run_t r;

      gs[0]  = 3'b100; ge[0]  = 3'b000;
      gs[1]  = 3'b001; ge[1]  = 3'b001;
      gs[2]  = 3'b001; ge[2]  = 3'b010;
      gs[3]  = 3'b010; ge[3]  = 3'b001;
      gs[4]  = 3'b010; ge[4]  = 3'b000;
      gs[5]  = 3'b010; ge[5]  = 3'b111;
      gs[6]  = 3'b001; ge[6]  = 3'b000;
      gs[7]  = 3'b011; ge[7]  = 3'b000;
      gs[8]  = 3'b001; ge[8]  = 3'b001;
      gs[9]  = 3'b001; ge[9]  = 3'b010;
      gs[10] = 3'b001; ge[10] = 3'b111;
      gs[11] = 3'b000; ge[11] = 3'b111;
      gs[12] = 3'b100; ge[12] = 3'b000;
      gs[13] = 3'b010; ge[13] = 3'b111;
      gs[14] = 3'b001; ge[14] = 3'b000;
      gs[15] = 3'b000; ge[15] = 3'b000;

      //          nv  reload corrupt   dist done mm ff fv  applied
      rows[0] = '{3,  1'b1, 16'h0000, 0,   45,  0, 0, 1'b0, 3};   // clean 3-vector run
      rows[1] = '{3,  1'b1, 16'h0002, 0,   45,  1, 1, 1'b1, 3};   // vector 1 corrupted
      rows[2] = '{0,  1'b0, 16'h0000, 0,   41,  0, 0, 1'b0, 0};   // empty run clears results
      rows[3] = '{3,  1'b1, 16'h0000, 5,   45,  0, 0, 1'b0, 3};   // start/cfg_we during warm-up
      rows[4] = '{3,  1'b0, 16'h0000, 0,   45,  0, 0, 1'b0, 3};   // memory untouched by that write
      rows[5] = '{20, 1'b1, 16'hffff, 0,   58, 16, 0, 1'b1, 16};  // clamp, all wrong
      rows[6] = '{16, 1'b1, 16'h8000, 0,   58,  1, 15, 1'b1, 16}; // only last vector wrong

      // Reset state.
      reset_pad = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {busy, done, input1, input2, fsm_reset, mismatch_cnt, first_fail, fail_valid}, '0);
      reset_pad = 1'b0;
      @(negedge clk);
      check("idle_after_reset_busy", busy, 1'b0);

      for (int i = 0; i < 7; i++) begin
         do_run($sformatf("row%0d", i), rows[i]);
      end

      // Results hold while idle.
      repeat (5) @(negedge clk);
      check("hold_results", {mismatch_cnt, first_fail, fail_valid}, {5'd1, 4'd15, 1'b1});

      // Reset outranks start and cfg_we in the same cycle.
      reset_pad    = 1'b1;
      start_pad    = 1'b1;
      cfg_we_pad   = 1'b1;
      cfg_addr_pad = 4'd2;
      cfg_data_pad = 6'h3f;
      @(negedge clk);
      check("rst_prio_busy_and_results", {busy, mismatch_cnt, fail_valid}, '0);
      reset_pad  = 1'b0;
      start_pad  = 1'b0;
      cfg_we_pad = 1'b0;
      @(negedge clk);
      check("rst_prio_no_start", busy, 1'b0);
      r = '{3, 1'b0, 16'h0000, 0, 45, 0, 0, 1'b0, 3};
      do_run("rst_prio_mem_kept", r);

      // Reset in the middle of APPLY while vector 2 of 8 is on the pins.
      load_mem(16'h0001);
      @(negedge clk);
      start_pad   = 1'b1;
      num_vec_pad = 5'd8;
      @(negedge clk);
      start_pad   = 1'b0;
      repeat (22) @(negedge clk);
      check("midrun_vec2_on_pins", {fsm_reset, input2, input1}, gs[2]);
      check("midrun_v0_scored", mismatch_cnt, 5'd1);
      reset_pad = 1'b1;
      @(negedge clk);
      check("midrun_reset_outputs",
            {busy, done, input1, input2, fsm_reset, mismatch_cnt, first_fail, fail_valid}, '0);
      reset_pad = 1'b0;
      r = '{8, 1'b0, 16'h0000, 0, 50, 1, 0, 1'b1, 8};
      do_run("midrun_rerun", r);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
